fifo16: RTL and testbench

Sixteen-entry first-word-fall-through FIFO that sits directly in front of the 16x1 dual-port distributed RAM primitive. It generates the primitive's write address, write enable and read address, and presents the read port as FIFO output. Storage is WIDTH instances of the 16x1 dual-port RAM, one per data bit:

- common write address = write pointer;
- read address (DPRA) = read pointer.

Typical users are the RISC5 UART receive/transmit paths and the PS/2 keyboard buffer.

---
 rtl/fifo16_if.sv | 28 ++
 rtl/fifo16.sv | 107 ++++++++++
 tb/tb_fifo16.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fifo16_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo16_if : push/pop/status bundle for fifo16 (rev 1.0)
// ---------------------------------------------------------------------------
interface fifo16_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             rd_en;
  logic             ovfl_clr;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [4:0]       count;
  logic             ovfl;

  modport master (
    output wr_data, wr_en, rd_en, ovfl_clr,
    input  rd_data, empty, full, count, ovfl
  );

  modport slave (
    input  wr_data, wr_en, rd_en, ovfl_clr,
    output rd_data, empty, full, count, ovfl
  );
endinterface
`default_nettype wire

// File: rtl/fifo16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo16 : 16-entry FWFT FIFO over per-bit 16x1 dual-port RAMs (rev 1.0)
// ---------------------------------------------------------------------------

// Behavioural 16x1 dual-port distributed RAM: synchronous write, async read.
module ram16x1d (
  input  wire logic       wclk,
  input  wire logic       we,
  input  wire logic [3:0] a,
  input  wire logic       d,
  input  wire logic [3:0] dpra,
  output logic            dpo
);
  logic [15:0] r_mem;

  always_ff @(posedge wclk) begin
    if (we) begin
      r_mem[a] <= d;
    end
  end

  assign dpo = r_mem[dpra];
endmodule

module fifo16 #(
  parameter int WIDTH = 8
) (
  input  wire logic clk,
  input  wire logic rst,
  fifo16_if.slave   bus
);
  localparam logic [4:0] C_DEPTH = 5'd16;

  logic [3:0] r_wr_ptr;
  logic [3:0] r_rd_ptr;
  logic [4:0] r_count;
  logic       r_empty;
  logic       r_full;
  logic       r_ovfl;

  logic       w_push;
  logic       w_pop;
  logic       w_we;
  logic [4:0] w_count_nxt;

  // Acceptance uses only registered flags, so a push is never taken while
  // full and the write can never land on the valid word at rd_ptr.
  assign w_push = bus.wr_en & ~r_full;
  assign w_pop  = bus.rd_en & ~r_empty;
  assign w_we   = w_push & ~rst;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 5'd1;
      2'b01:   w_count_nxt = r_count - 5'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 4'd0;
      r_rd_ptr <= 4'd0;
      r_count  <= 5'd0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_ovfl   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 4'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 4'd1;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == 5'd0);
      r_full  <= (w_count_nxt == C_DEPTH);
      // A rejected push and a clear in the same cycle leave the flag set.
      if (bus.wr_en && r_full) begin
        r_ovfl <= 1'b1;
      end else if (bus.ovfl_clr) begin
        r_ovfl <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      ram16x1d u_ram (
        .wclk (clk),
        .we   (w_we),
        .a    (r_wr_ptr),
        .d    (bus.wr_data[gi]),
        .dpra (r_rd_ptr),
        .dpo  (bus.rd_data[gi])
      );
    end
  endgenerate

  assign bus.empty = r_empty;
  assign bus.full  = r_full;
  assign bus.count = r_count;
  assign bus.ovfl  = r_ovfl;
endmodule
`default_nettype wire

// File: tb/tb_fifo16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo16 : queue-model scoreboard bench for fifo16 (rev 1.0)
// ---------------------------------------------------------------------------
module tb_fifo16;
  logic clk = 1'b0;
  logic rst = 1'b0;

  fifo16_if #(.WIDTH(8)) bus ();

  fifo16 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of words plus the sticky overflow bit.
  logic [7:0] mdl[$];
  logic [7:0] exp_q[$];
  bit         mdl_ovfl = 1'b0;
  bit         started  = 1'b0;

  // Model view of the DUT state during the current cycle.
  bit         chk_en    = 1'b0;
  int         cur_count = 0;
  bit         cur_ovfl  = 1'b0;
  logic [7:0] cur_head  = 8'h00;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input bit w, input bit r, input logic [7:0] d,
                     input bit clr = 1'b0, input bit rs = 1'b0);
    bit do_pop;
    bit do_push;
    @(negedge clk);
    rst          = rs;
    bus.wr_en    = w;
    bus.rd_en    = r;
    bus.wr_data  = d;
    bus.ovfl_clr = clr;
    chk_en    = started;
    cur_count = mdl.size();
    cur_ovfl  = mdl_ovfl;
    cur_head  = (mdl.size() > 0) ? mdl[0] : 8'h00;
    if (rs) begin
      mdl.delete();
      mdl_ovfl = 1'b0;
      started  = 1'b1;
    end else begin
      do_pop  = r && (mdl.size() > 0);
      do_push = w && (mdl.size() < 16);
      if (w && mdl.size() == 16) mdl_ovfl = 1'b1;
      else if (clr)              mdl_ovfl = 1'b0;
      if (do_pop)  exp_q.push_back(mdl.pop_front());
      if (do_push) mdl.push_back(d);
    end
  endtask

  // Monitor: samples mid-cycle, checks status and consumes scoreboard entries.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("count", 32'(bus.count), 32'(cur_count));
      chk("empty", 32'(bus.empty), 32'(cur_count == 0));
      chk("full",  32'(bus.full),  32'(cur_count == 16));
      chk("ovfl",  32'(bus.ovfl),  32'(cur_ovfl));
      if (cur_count > 0) chk("head", 32'(bus.rd_data), 32'(cur_head));
      if (!rst && bus.rd_en && bus.empty === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL pop_unexpected at %0t: got %0h expected no pop", $time, bus.rd_data);
        end else begin
          chk("pop_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = 8'h00; bus.ovfl_clr = 1'b0;
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00);

    // Fill, overflow push, drain
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i));
    cyc(1, 0, 8'hAA);
    cyc(0, 0, 8'h00);
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00, 1);

    // Single word latency
    cyc(1, 0, 8'h5A);
    cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);

    // Pointer wrap
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 8'(8'h80 + i));
      cyc(0, 1, 8'h00);
    end
    for (int i = 0; i < 12; i++) cyc(1, 0, 8'(8'h30 + i));
    for (int i = 0; i < 12; i++) cyc(0, 1, 8'h00);

    // Simultaneous push+pop at count 5, at full, at empty
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h50 + i));
    cyc(1, 1, 8'h55);
    cyc(1, 1, 8'h56);
    for (int i = 0; i < 11; i++) cyc(1, 0, 8'(8'h60 + i));
    cyc(1, 1, 8'hEE);
    cyc(0, 0, 8'h00);
    for (int i = 0; i < 15; i++) cyc(0, 1, 8'h00);
    cyc(1, 1, 8'h77, 1);
    cyc(0, 0, 8'h00);
    cyc(0, 1, 8'h00);

    // Pop while empty, then push
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h00);
    cyc(1, 0, 8'h11);
    cyc(0, 1, 8'h00);

    // Mid-operation reset, then clear colliding with overflow
    for (int i = 0; i < 7; i++) cyc(1, 0, 8'(8'hC0 + i));
    cyc(1, 1, 8'hFF, 0, 1);
    cyc(0, 0, 8'h00);
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'hD0 + i));
    cyc(1, 0, 8'h99, 1);
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00, 1);

    // Randomized traffic with phases biased toward full and toward empty
    for (int ph = 0; ph < 12; ph++) begin
      int pw;
      int pr;
      pw = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 50;
      pr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 50;
      for (int i = 0; i < 200; i++) begin
        cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
            8'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
      end
    end
    for (int i = 0; i < 18; i++) cyc(0, 1, 8'h00);

    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #4;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
